// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_multiplier
//  Purpose  : Sequential shift-and-add multiplier. One multiplier (q) bit is
//             consumed per clock, with optional two's-complement operands.
//             A start/busy/done handshake frames each operation. The product
//             is held stable between completions.
//  Ports    : clock  - system clock, rising edge active
//             reset  - asynchronous active-high reset
//             start  - operation request, sampled only while idle
//             m      - multiplicand [M_WIDTH], captured on the accepting edge
//             q      - multiplier   [Q_WIDTH], captured on the accepting edge
//             busy   - high while an operation is in progress
//             done   - one-cycle pulse marking a new product on p
//             p      - product [M_WIDTH+Q_WIDTH]
//  Revision : 1.0  initial release
// ============================================================================
module seq_multiplier #(
    parameter int M_WIDTH = 2,
    parameter int Q_WIDTH = 3,
    parameter int SIGNED  = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [M_WIDTH-1:0]         m,
    input  logic [Q_WIDTH-1:0]         q,
    output logic                       busy,
    output logic                       done,
    output logic [M_WIDTH+Q_WIDTH-1:0] p
);

    localparam int P_WIDTH = M_WIDTH + Q_WIDTH;
    localparam int CW      = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;

    localparam logic [CW-1:0] C_LAST = CW'(Q_WIDTH - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [P_WIDTH-1:0] r_mcand;   // m pre-extended, shifted left one place per step
    logic [Q_WIDTH-1:0] r_mplier;  // q, shifted right so bit 0 is the current step's bit
    logic [P_WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [P_WIDTH-1:0] r_p;

    logic [P_WIDTH-1:0] w_m_ext;
    logic               w_last;
    logic [P_WIDTH-1:0] w_sum;
    logic [P_WIDTH-1:0] w_acc_next;

    // Widen m to the product width once at capture time so every later
    // add/subtract is a plain P_WIDTH operation.
    generate
        if (SIGNED != 0) begin : g_ext_signed
            assign w_m_ext = {{Q_WIDTH{m[M_WIDTH-1]}}, m};
        end else begin : g_ext_unsigned
            assign w_m_ext = {{Q_WIDTH{1'b0}}, m};
        end
    endgenerate

    assign w_last = (r_cnt == C_LAST);

    // In two's complement the top multiplier bit carries negative weight,
    // so the final partial product is subtracted rather than added.
    always_comb begin
        w_sum = r_acc + r_mcand;
        if ((SIGNED != 0) && w_last) begin
            w_sum = r_acc - r_mcand;
        end
        w_acc_next = r_mplier[0] ? w_sum : r_acc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_p      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= w_m_ext;
                        r_mplier <= q;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= {1'b0, r_mplier[Q_WIDTH-1:1]};
                    if (w_last) begin
                        // Final step goes straight to p so p only ever
                        // changes to a complete product.
                        r_p     <= w_acc_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_multiplier
//  Purpose  : Self-checking bench for seq_multiplier. Three instances cover
//             2x3 unsigned, 8x8 unsigned and 4x4 signed configurations.
//             A reference model predicts busy/done/p from the operand
//             arithmetic; directed vectors add literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [1:0] m0 = '0;
    logic [2:0] q0 = '0;
    logic [7:0] m1 = '0, q1 = '0;
    logic [3:0] m2 = '0, q2 = '0;

    logic        busy0, done0, busy1, done1, busy2, done2;
    logic [4:0]  p0;
    logic [15:0] p1;
    logic [7:0]  p2;

    seq_multiplier u_dut0 (
        .clock(clk), .reset(rst), .start(start0), .m(m0), .q(q0),
        .busy(busy0), .done(done0), .p(p0)
    );

    seq_multiplier #(.M_WIDTH(8), .Q_WIDTH(8), .SIGNED(0)) u_dut1 (
        .clock(clk), .reset(rst), .start(start1), .m(m1), .q(q1),
        .busy(busy1), .done(done1), .p(p1)
    );

    seq_multiplier #(.M_WIDTH(4), .Q_WIDTH(4), .SIGNED(1)) u_dut2 (
        .clock(clk), .reset(rst), .start(start2), .m(m2), .q(q2),
        .busy(busy2), .done(done2), .p(p2)
    );

    int total = 0;
    int bad   = 0;
    logic armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An accepted request yields the full arithmetic product after Q
    // further edges; busy covers exactly those edges.
    logic        eb0, ed0, eb1, ed1, eb2, ed2;
    logic [4:0]  ep0, ea0;
    logic [15:0] ep1, ea1;
    logic [7:0]  ep2, ea2;
    int          ec0, ec1, ec2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eb0 <= 1'b0; ed0 <= 1'b0; ep0 <= '0; ec0 <= 0;
        end else if (eb0) begin
            ec0 <= ec0 - 1;
            ed0 <= (ec0 == 1);
            if (ec0 == 1) begin eb0 <= 1'b0; ep0 <= ea0; end
        end else begin
            ed0 <= 1'b0;
            if (start0) begin eb0 <= 1'b1; ec0 <= 3; ea0 <= 5'(int'(m0) * int'(q0)); end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eb1 <= 1'b0; ed1 <= 1'b0; ep1 <= '0; ec1 <= 0;
        end else if (eb1) begin
            ec1 <= ec1 - 1;
            ed1 <= (ec1 == 1);
            if (ec1 == 1) begin eb1 <= 1'b0; ep1 <= ea1; end
        end else begin
            ed1 <= 1'b0;
            if (start1) begin eb1 <= 1'b1; ec1 <= 8; ea1 <= 16'(int'(m1) * int'(q1)); end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eb2 <= 1'b0; ed2 <= 1'b0; ep2 <= '0; ec2 <= 0;
        end else if (eb2) begin
            ec2 <= ec2 - 1;
            ed2 <= (ec2 == 1);
            if (ec2 == 1) begin eb2 <= 1'b0; ep2 <= ea2; end
        end else begin
            ed2 <= 1'b0;
            if (start2) begin
                eb2 <= 1'b1; ec2 <= 4;
                ea2 <= 8'(int'($signed(m2)) * int'($signed(q2)));
            end
        end
    end

    // ---------------- cycle compare ----------------
    always @(negedge clk) begin
        if (armed) begin
            chk("busy0", {31'b0, busy0}, {31'b0, eb0});
            chk("done0", {31'b0, done0}, {31'b0, ed0});
            chk("p0", {27'b0, p0}, {27'b0, ep0});
            chk("busy1", {31'b0, busy1}, {31'b0, eb1});
            chk("done1", {31'b0, done1}, {31'b0, ed1});
            chk("p1", {16'b0, p1}, {16'b0, ep1});
            chk("busy2", {31'b0, busy2}, {31'b0, eb2});
            chk("done2", {31'b0, done2}, {31'b0, ed2});
            chk("p2", {24'b0, p2}, {24'b0, ep2});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int sel, input logic s, input logic [7:0] mm, input logic [7:0] qq);
        case (sel)
            0: begin start0 = s; m0 = mm[1:0]; q0 = qq[2:0]; end
            1: begin start1 = s; m1 = mm;      q1 = qq;      end
            default: begin start2 = s; m2 = mm[3:0]; q2 = qq[3:0]; end
        endcase
    endtask

    task automatic sample(input int sel, output logic d, output logic b, output logic [15:0] pv);
        case (sel)
            0: begin d = done0; b = busy0; pv = {11'b0, p0}; end
            1: begin d = done1; b = busy1; pv = p1; end
            default: begin d = done2; b = busy2; pv = {8'b0, p2}; end
        endcase
    endtask

    // One operation: check literal product, done latency and busy length.
    // Operands are scrambled right after acceptance to show they are ignored.
    task automatic op(input int sel, input logic [7:0] mm, input logic [7:0] qq, input logic [15:0] ex);
        int qw, dk, bc;
        logic d, b;
        logic [15:0] pv;
        qw = (sel == 0) ? 3 : (sel == 1) ? 8 : 4;
        dk = 0; bc = 0;
        @(negedge clk);
        drive(sel, 1'b1, mm, qq);
        for (int k = 1; k <= qw + 3; k++) begin
            @(negedge clk);
            if (k == 1) drive(sel, 1'b0, ~mm, ~qq);
            sample(sel, d, b, pv);
            if (b) bc++;
            if (d && dk == 0) begin
                dk = k;
                chk($sformatf("p_lit%0d", sel), {16'b0, pv}, {16'b0, ex});
            end
        end
        chk($sformatf("latency%0d", sel), dk, qw + 1);
        chk($sformatf("busy_len%0d", sel), bc, qw);
    endtask

    // ---------------- main sequence ----------------
    typedef struct { logic [7:0] m; logic [7:0] q; logic [15:0] p; } vec_t;

    initial begin
        vec_t legacy[9];
        vec_t b2b[4];
        int dk, dc, bc, r, lastk, ld;
        logic prevd;

        legacy = '{'{8'd0, 8'd0, 16'h00}, '{8'd1, 8'd0, 16'h00}, '{8'd1, 8'd1, 16'h01},
                   '{8'd1, 8'd6, 16'h06}, '{8'd2, 8'd5, 16'h0A}, '{8'd2, 8'd6, 16'h0C},
                   '{8'd3, 8'd3, 16'h09}, '{8'd3, 8'd6, 16'h12}, '{8'd3, 8'd7, 16'h15}};
        b2b = '{'{8'd1, 8'd6, 16'h06}, '{8'd3, 8'd7, 16'h15},
                '{8'd2, 8'd5, 16'h0A}, '{8'd3, 8'd3, 16'h09}};

        #1 rst = 1'b1;
        #1;
        chk("rst_busy0", {31'b0, busy0}, 32'd0);
        chk("rst_done0", {31'b0, done0}, 32'd0);
        chk("rst_p0", {27'b0, p0}, 32'd0);
        chk("rst_p1", {16'b0, p1}, 32'd0);
        chk("rst_p2", {24'b0, p2}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        armed = 1'b1;

        // Legacy 2x3 unsigned vectors
        foreach (legacy[i]) op(0, legacy[i].m, legacy[i].q, legacy[i].p);

        // 8x8 unsigned
        op(1, 8'd255, 8'd255, 16'hFE01);
        op(1, 8'd0, 8'd0, 16'h0000);

        // 4x4 signed
        op(2, 8'h0D, 8'h05, 16'h00F1);
        op(2, 8'h08, 8'h08, 16'h0040);
        op(2, 8'h07, 8'h0F, 16'h00F9);
        op(2, 8'h00, 8'h08, 16'h0000);

        // Start while busy: second request must be ignored
        @(negedge clk);
        start0 = 1'b1; m0 = 2'd3; q0 = 3'd7;
        dk = 0; dc = 0; bc = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin start0 = 1'b1; m0 = 2'd1; q0 = 3'd1; end
            if (k == 2) begin start0 = 1'b0; m0 = 2'd2; q0 = 3'd2; end
            if (busy0) bc++;
            if (done0) begin
                dc++;
                if (dk == 0) dk = k;
                chk("busy_start_p", {27'b0, p0}, 32'h15);
            end
        end
        chk("busy_start_dones", dc, 1);
        chk("busy_start_lat", dk, 4);
        chk("busy_start_blen", bc, 3);

        // Back-to-back with start held high
        r = 0; lastk = 0; ld = 0; prevd = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (done0) begin
                if (r < 4) chk("b2b_p", {27'b0, p0}, {16'b0, b2b[r].p});
                if (r > 0) chk("b2b_gap", k - lastk, 4);
                lastk = k;
                r++;
            end
            if (prevd && done0) chk("b2b_double_done", 32'd1, 32'd0);
            prevd = done0;
            if (!busy0 && ld < 4) begin
                start0 = 1'b1; m0 = b2b[ld].m[1:0]; q0 = b2b[ld].q[2:0];
                ld++;
            end else if (ld == 4 && busy0) begin
                start0 = 1'b0;
            end
        end
        start0 = 1'b0;
        chk("b2b_count", r, 4);

        // Asynchronous reset in the middle of 3x7
        @(negedge clk);
        start0 = 1'b1; m0 = 2'd3; q0 = 3'd7;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'b0, busy0}, 32'd0);
        chk("mid_rst_done", {31'b0, done0}, 32'd0);
        chk("mid_rst_p", {27'b0, p0}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dc = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (done0) dc++;
        end
        chk("mid_rst_no_done", dc, 0);
        op(0, 8'd2, 8'd5, 16'h0A);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
